// File: rtl/soc_addr_decoder_pkg.sv
// ---------------------------------------------------------------------------
// ariane_soc : shared SoC address-map package.
// Purpose : holds the crossbar slave count, the base/length constants of the
//           SoC memory map, the region-rule record used by the runtime
//           programmable address decoder, and the reset-time default table.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package ariane_soc;

    // Number of crossbar slave ports; drives the decoder's NrSlaves default.
    localparam int NB_PERIPHERALS  = 5;
    // Storage width of rule addresses; decoder AddrWidth must not exceed it.
    localparam int MaxAddrWidth    = 64;
    localparam int SlaveFieldWidth = $clog2(NB_PERIPHERALS);
    localparam int NrDefaultRules  = 5;

    typedef enum logic [SlaveFieldWidth-1:0] {
        SLV_DRAM  = 3'd0,
        SLV_UART  = 3'd1,
        SLV_CLINT = 3'd2,
        SLV_PERIP = 3'd3,
        SLV_DEBUG = 3'd4
    } soc_slave_e;

    localparam logic [63:0] DRAMBase    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DRAMLength  = 64'h0000_0000_4000_0000;
    localparam logic [63:0] UARTBase    = 64'h0000_0000_1000_0000;
    localparam logic [63:0] UARTLength  = 64'h0000_0000_0000_1000;
    localparam logic [63:0] CLINTBase   = 64'h0000_0000_0200_0000;
    localparam logic [63:0] CLINTLength = 64'h0000_0000_000C_0000;
    localparam logic [63:0] PERIPBase   = 64'h0000_0000_2000_0000;
    localparam logic [63:0] PERIPLength = 64'h0000_0000_6000_0000;
    localparam logic [63:0] DebugBase   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] DebugLength = 64'h0000_0000_0000_1000;

    typedef struct packed {
        logic [MaxAddrWidth-1:0]    base;
        logic [MaxAddrWidth-1:0]    len;
        logic [SlaveFieldWidth-1:0] slave;
        logic                       en;
    } addr_rule_t;

    // Reset-time content of rule idx; indices past the SoC map are disabled.
    function automatic addr_rule_t default_rule(input int idx);
        addr_rule_t r;
        r = '0;
        case (idx)
            0:       r = '{base: DRAMBase,  len: DRAMLength,  slave: SLV_DRAM,  en: 1'b1};
            1:       r = '{base: UARTBase,  len: UARTLength,  slave: SLV_UART,  en: 1'b1};
            2:       r = '{base: CLINTBase, len: CLINTLength, slave: SLV_CLINT, en: 1'b1};
            3:       r = '{base: PERIPBase, len: PERIPLength, slave: SLV_PERIP, en: 1'b1};
            4:       r = '{base: DebugBase, len: DebugLength, slave: SLV_DEBUG, en: 1'b1};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/soc_addr_decoder_if.sv
// ---------------------------------------------------------------------------
// soc_addr_decoder_if : request/response handshake bundle of the decoder.
// Purpose : carries the address request stream (req_*) into the decoder and
//           the registered decode result (rsp_*) back out.
// Signals : req_valid/req_ready/req_addr  - request handshake and address
//           rsp_valid/rsp_ready           - result handshake
//           rsp_slave/rsp_rule/rsp_err    - selected slave, rule, miss flag
// Modports: master (request source / result sink), slave (the decoder).
// ---------------------------------------------------------------------------
interface soc_addr_decoder_if #(
    parameter int AddrWidth  = 64,
    parameter int SlaveWidth = 3,
    parameter int RuleWidth  = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic [AddrWidth-1:0]  req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [SlaveWidth-1:0] rsp_slave;
    logic [RuleWidth-1:0]  rsp_rule;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_slave, rsp_rule, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_slave, rsp_rule, rsp_err
    );
endinterface

// File: rtl/soc_addr_decoder_rule_match.sv
// ---------------------------------------------------------------------------
// soc_addr_rule_match : combinational hit test of one address region rule.
// Purpose : hit_o = en && base <= addr < base+len. The upper bound is formed
//           one bit wider than the address so a region ending exactly at the
//           top of the address space does not wrap to zero; len=0 never hits.
// Ports   : rule_i (region rule), addr_i (address), hit_o (rule matches).
// ---------------------------------------------------------------------------
module soc_addr_rule_match
    import ariane_soc::*;
(
    input  addr_rule_t              rule_i,
    input  logic [MaxAddrWidth-1:0] addr_i,
    output logic                    hit_o
);
    logic [MaxAddrWidth:0] limit;
    logic                  unused_slave;

    assign limit        = {1'b0, rule_i.base} + {1'b0, rule_i.len};
    assign unused_slave = ^rule_i.slave;
    assign hit_o        = rule_i.en
                        && (rule_i.len != '0)
                        && (addr_i >= rule_i.base)
                        && ({1'b0, addr_i} < limit);
endmodule

// File: rtl/soc_addr_decoder.sv
// ---------------------------------------------------------------------------
// soc_addr_decoder : runtime-programmable SoC address decoder.
// Purpose : NrRules region rules (reset to the ariane_soc default map) decode
//           a request stream to a slave index through one registered
//           valid/ready stage. Boot firmware may rewrite rules and lock them.
// Ports   : clk_i, rst_i (async, active-high)
//           cfg_we_i/cfg_idx_i/cfg_base_i/cfg_len_i/cfg_slave_i/cfg_en_i/
//           cfg_lock_i - rule write port; cfg_err_o - rejected-write pulse;
//           locked_o - table frozen; bus - soc_addr_decoder_if.slave
//           (req_*/rsp_*); miss_cnt_o - saturating miss counter.
// Option  : SOC_ADDR_DEC_DEFAULT_PORT_EN - misses route to DefaultSlave with
//           rsp_err=0 instead of flagging an error.
// ---------------------------------------------------------------------------
module soc_addr_decoder
    import ariane_soc::*;
#(
    parameter int NrRules   = 8,
    parameter int NrSlaves  = NB_PERIPHERALS,
    parameter int AddrWidth = 64,
    parameter int CntWidth  = 16,
`ifdef SOC_ADDR_DEC_DEFAULT_PORT_EN
    parameter int DefaultSlave = 0,
`endif
    localparam int SlaveW = (NrSlaves > 1) ? $clog2(NrSlaves) : 1,
    localparam int RuleW  = (NrRules > 1) ? $clog2(NrRules) : 1,
    // One spare bit so an out-of-range index can be presented and rejected.
    localparam int IdxW   = $clog2(NrRules + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic [SlaveW-1:0]    cfg_slave_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_err_o,
    output logic                 locked_o,
    soc_addr_decoder_if.slave    bus,
    output logic [CntWidth-1:0]  miss_cnt_o
);
    addr_rule_t              rules_q [NrRules];
    addr_rule_t              rules_d [NrRules];
    logic                    rsp_valid_q, rsp_valid_d;
    logic [SlaveW-1:0]       rsp_slave_q, rsp_slave_d;
    logic [RuleW-1:0]        rsp_rule_q,  rsp_rule_d;
    logic                    rsp_err_q,   rsp_err_d;
    logic [CntWidth-1:0]     miss_cnt_q,  miss_cnt_d;
    logic                    locked_q,    locked_d;
    logic                    cfg_err_q,   cfg_err_d;

    logic [NrRules-1:0]      hit;
    logic [MaxAddrWidth-1:0] addr_ext;
    logic                    req_ready;
    logic                    accept;
    logic                    match_found;
    logic [RuleW-1:0]        match_idx;
    logic [SlaveW-1:0]       dec_slave;
    logic [RuleW-1:0]        dec_rule;
    logic                    dec_err;
    logic                    cfg_bad;
    addr_rule_t              cfg_rule;

    assign addr_ext  = MaxAddrWidth'(bus.req_addr);
    assign req_ready = !rsp_valid_q || bus.rsp_ready;
    assign accept    = bus.req_valid && req_ready;

    for (genvar g = 0; g < NrRules; g++) begin : g_match
        soc_addr_rule_match u_match (
            .rule_i (rules_q[g]),
            .addr_i (addr_ext),
            .hit_o  (hit[g])
        );
    end

    // Priority encoder: walking downwards lets the lowest matching index win.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = NrRules - 1; i >= 0; i--) begin
            match_found = match_found | hit[i];
            match_idx   = hit[i] ? RuleW'(i) : match_idx;
        end
    end

    // Decode result for the current request, including the miss encoding.
    always_comb begin
        dec_slave = '0;
        dec_rule  = '0;
        dec_err   = 1'b0;
        if (match_found) begin
            dec_slave = SlaveW'(rules_q[match_idx].slave);
            dec_rule  = match_idx;
        end else begin
`ifdef SOC_ADDR_DEC_DEFAULT_PORT_EN
            dec_slave = SlaveW'(DefaultSlave);
            dec_err   = 1'b0;
`else
            dec_slave = '0;
            dec_err   = 1'b1;
`endif
        end
    end

    // Next state: result stage, miss counter, rule table, lock and write error.
    always_comb begin
        rsp_valid_d = accept || (rsp_valid_q && !bus.rsp_ready);
        rsp_slave_d = rsp_slave_q;
        rsp_rule_d  = rsp_rule_q;
        rsp_err_d   = rsp_err_q;
        miss_cnt_d  = miss_cnt_q;
        rules_d     = rules_q;
        cfg_rule    = '{base:  MaxAddrWidth'(cfg_base_i),
                        len:   MaxAddrWidth'(cfg_len_i),
                        slave: SlaveFieldWidth'(cfg_slave_i),
                        en:    cfg_en_i};

        if (accept) begin
            rsp_slave_d = dec_slave;
            rsp_rule_d  = dec_rule;
            rsp_err_d   = dec_err;
        end else begin
            rsp_err_d   = rsp_err_q;
        end

        if (accept && !match_found && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CntWidth'(1);
        end else begin
            miss_cnt_d = miss_cnt_q;
        end

        // Decode above reads rules_q, so a write this cycle lands after it.
        cfg_bad   = cfg_we_i && (locked_q || (cfg_idx_i >= IdxW'(NrRules)));
        cfg_err_d = cfg_bad;
        if (cfg_we_i && !cfg_bad) begin
            rules_d[cfg_idx_i[RuleW-1:0]] = cfg_rule;
        end else begin
            rules_d = rules_q;
        end
        locked_d = locked_q || (cfg_we_i && cfg_lock_i && !cfg_bad);
    end

    // State registers; reset reloads the default map and drops any result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrRules; i++) begin
                rules_q[i] <= default_rule(i);
            end
            rsp_valid_q <= 1'b0;
            rsp_slave_q <= '0;
            rsp_rule_q  <= '0;
            rsp_err_q   <= 1'b0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            rules_q     <= rules_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_slave_q <= rsp_slave_d;
            rsp_rule_q  <= rsp_rule_d;
            rsp_err_q   <= rsp_err_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_slave = rsp_slave_q;
    assign bus.rsp_rule  = rsp_rule_q;
    assign bus.rsp_err   = rsp_err_q;
    assign cfg_err_o     = cfg_err_q;
    assign locked_o      = locked_q;
    assign miss_cnt_o    = miss_cnt_q;
endmodule
